// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared types and constants for the i2s receive sequencer
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2,
    STOP = 2'd3
  } state_t;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  localparam int DEFAULT_DEPTH = 8;

endpackage

// File: rtl/i2s_rx_fifo.sv
// rtl/i2s_rx_fifo.sv - first-word-fall-through FIFO of 32-bit words with a channel tag
module i2s_rx_fifo
  import i2s_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [32:0]   wdata,
  input  logic          pop,
  input  logic          flush,
  output logic [32:0]   rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [32:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_pop;
  logic          w_push;

  assign empty  = (r_count == '0);
  assign full   = (r_count == CW'(DEPTH));
  assign w_pop  = pop && !empty;
  // A push into a full FIFO is only legal because a pop frees the slot this cycle.
  assign w_push = push && (!full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr_ptr] <= wdata;
  end

  assign rdata = empty ? '0 : r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

// File: rtl/i2s_rx_ctrl.sv
// rtl/i2s_rx_ctrl.sv - gates the i2s core, filters and buffers words, requests DMA service
module i2s_rx_ctrl
  import i2s_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_en,
  input  logic [1:0]    cfg_chan,
  input  logic [CW-1:0] cfg_thresh,
  input  logic          fifo_flush,
  input  logic          ovf_clr,
  output logic          i2s_en,
  input  logic          i2s_done,
  input  logic [31:0]   i2s_data,
  input  logic          i2s_ws,
  output logic          dma_req,
  input  logic          dma_ack,
  output logic [31:0]   rd_data,
  output logic          rd_chan,
  output logic [CW-1:0] count,
  output logic          busy,
  output logic          ovf
);

  state_t        r_state;
  logic          r_i2s_en;
  logic          r_cap_vld;
  logic [31:0]   r_cap_data;
  logic          r_cap_chan;
  logic          r_ovf;
  logic [1:0]    w_chan;
  logic          w_accept;
  logic          w_full;
  logic          w_empty;
  logic          w_drop;
  logic [32:0]   w_rdata;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_eff_thresh;

  assign w_chan   = (cfg_chan == 2'b00) ? 2'b11 : cfg_chan;
  assign w_accept = (i2s_ws == CH_LEFT) ? w_chan[0] : w_chan[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_i2s_en   <= 1'b0;
      r_cap_vld  <= 1'b0;
      r_cap_data <= '0;
      r_cap_chan <= CH_LEFT;
    end else begin
      r_cap_vld <= 1'b0;
      case (r_state)
        IDLE: if (cfg_en) begin
          r_state  <= SYNC;
          r_i2s_en <= 1'b1;
        end
        // The first word after enabling was only partly shifted in, so it is dropped.
        SYNC: if (i2s_done) begin
          r_state <= RUN;
        end else if (!cfg_en) begin
          r_state  <= IDLE;
          r_i2s_en <= 1'b0;
        end
        RUN: if (!cfg_en) r_state <= STOP;
        STOP: if (i2s_done) begin
          r_state  <= IDLE;
          r_i2s_en <= 1'b0;
        end else if (cfg_en) begin
          r_state <= RUN;
        end
        default: r_state <= IDLE;
      endcase
      if ((r_state == RUN || r_state == STOP) && i2s_done && w_accept) begin
        r_cap_vld  <= 1'b1;
        r_cap_data <= i2s_data;
        r_cap_chan <= i2s_ws;
      end
    end
  end

  // When full, dma_ack is always an effective pop, so the push then goes through.
  assign w_drop = r_cap_vld && w_full && !dma_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_ovf <= 1'b0;
    else if (w_drop)  r_ovf <= 1'b1;
    else if (ovf_clr) r_ovf <= 1'b0;
  end

  i2s_rx_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (r_cap_vld),
    .wdata ({r_cap_chan, r_cap_data}),
    .pop   (dma_ack),
    .flush (fifo_flush),
    .rdata (w_rdata),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  always_comb begin
    w_eff_thresh = cfg_thresh;
    if (cfg_thresh == '0)               w_eff_thresh = CW'(1);
    else if (cfg_thresh > CW'(DEPTH))   w_eff_thresh = CW'(DEPTH);
  end

  assign i2s_en  = r_i2s_en;
  assign busy    = (r_state != IDLE);
  assign ovf     = r_ovf;
  assign count   = w_count;
  assign dma_req = (w_count >= w_eff_thresh);
  assign rd_data = w_rdata[31:0];
  assign rd_chan = w_rdata[32] & ~w_empty;

endmodule
